// File: rtl/spi_cfg_slave.sv
// spi_cfg_slave: 3-wire SPI configuration responder with a byte register file.
// CE/SCLK/SDIO are oversampled on clk. A frame is a 1- or 2-byte instruction
// followed by one data byte. A read of PLL_ADDR returns the live PLL lock bit.
// Optional build macro SPI_CFG_SLAVE_STREAM_EN: when it is defined, further
// data bytes in the same frame continue at incrementing addresses.
module spi_cfg_slave #(
    parameter int          REG_DEPTH = 64,
    parameter logic [12:0] PLL_ADDR  = 13'h1F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_addr_2byte,
    input  logic        spi_ce,
    input  logic        spi_sclk,
    input  logic        spi_in,
    output logic        spi_out,
    output logic        spi_oe,
    input  logic        pll_lock_in,
    output logic        wr_valid,
    output logic [12:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        frame_err
);

    localparam int          AW      = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
    localparam logic [12:0] DEPTH13 = 13'(REG_DEPTH);
`ifdef SPI_CFG_SLAVE_STREAM_EN
    localparam logic STREAM = 1'b1;
`else
    localparam logic STREAM = 1'b0;
`endif

    // ST_WAIT is the "frame done, ignore SCLK until CE rises" phase.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_INSTR = 3'd1;
    localparam logic [2:0] ST_WDATA = 3'd2;
    localparam logic [2:0] ST_RDATA = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;

    logic ce_s1_q, ce_s2_q, sclk_s1_q, sclk_s2_q, sclk_d_q, in_s1_q, in_s2_q;
    logic sclk_rise, sclk_fall;

    logic [2:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] sr_q, sr_d;
    logic [12:0] addr_q, addr_d;
    logic        two_q, two_d;
    logic [7:0]  rd_sh_q, rd_sh_d;
    logic        out_q, out_d, oe_q, oe_d;
    logic        wr_valid_q, wr_valid_d, frame_err_q, frame_err_d;
    logic [12:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [REG_DEPTH-1:0][7:0] regs_q;

    logic        we;
    logic [15:0] sr_shift;
    logic [4:0]  instr_last;
    logic [12:0] dec_addr, addr_inc;
    logic        dec_rw;
    logic [7:0]  next_byte;

    // Read mux: PLL status overrides the file, out-of-range reads return zero.
    function automatic logic [7:0] rd_sel(input logic [12:0] a,
                                          input logic [REG_DEPTH-1:0][7:0] r,
                                          input logic lock);
        if (a == PLL_ADDR)     return {7'b0, lock};
        else if (a < DEPTH13)  return r[a[AW-1:0]];
        else                   return 8'h00;
    endfunction

    // Two-flop synchronisers plus a delayed SCLK copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_s1_q   <= 1'b1;
            ce_s2_q   <= 1'b1;
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_d_q  <= 1'b0;
            in_s1_q   <= 1'b0;
            in_s2_q   <= 1'b0;
        end else begin
            ce_s1_q   <= spi_ce;
            ce_s2_q   <= ce_s1_q;
            sclk_s1_q <= spi_sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_d_q  <= sclk_s2_q;
            in_s1_q   <= spi_in;
            in_s2_q   <= in_s1_q;
        end
    end

    assign sclk_rise  = sclk_s2_q & ~sclk_d_q;
    assign sclk_fall  = ~sclk_s2_q & sclk_d_q;
    assign sr_shift   = {sr_q[14:0], in_s2_q};
    assign instr_last = two_q ? 5'd15 : 5'd7;
    assign dec_addr   = two_q ? sr_shift[12:0] : {6'b0, sr_shift[6:0]};
    assign dec_rw     = two_q ? sr_shift[15] : sr_shift[7];
    assign addr_inc   = addr_q + 13'd1;
    assign next_byte  = rd_sel(addr_inc, regs_q, pll_lock_in);

    // Frame FSM. CE rising is checked before SCLK so a simultaneous final edge aborts.
    // In RDATA cnt counts master sampling rises; the byte is complete at 8.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        addr_d      = addr_q;
        two_d       = two_q;
        rd_sh_d     = rd_sh_q;
        out_d       = out_q;
        oe_d        = oe_q;
        wr_valid_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        we          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                oe_d  = 1'b0;
                out_d = 1'b0;
                if (!ce_s2_q) begin
                    state_d = ST_INSTR;
                    cnt_d   = 5'd0;
                    sr_d    = 16'h0000;
                    two_d   = spi_addr_2byte;
                end
            end
            ST_INSTR: begin
                if (ce_s2_q) begin
                    state_d     = ST_IDLE;
                    frame_err_d = (cnt_q != 5'd0);
                end else if (sclk_rise) begin
                    sr_d  = sr_shift;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == instr_last) begin
                        addr_d = dec_addr;
                        cnt_d  = 5'd0;
                        if (dec_rw) begin
                            state_d = ST_RDATA;
                            rd_sh_d = rd_sel(dec_addr, regs_q, pll_lock_in);
                        end else begin
                            state_d = ST_WDATA;
                        end
                    end
                end
            end
            ST_WDATA: begin
                if (ce_s2_q) begin
                    state_d     = ST_IDLE;
                    frame_err_d = (cnt_q != 5'd0);
                end else if (sclk_rise) begin
                    sr_d  = sr_shift;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd7) begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_data_d  = sr_shift[7:0];
                        we         = (addr_q < DEPTH13) && (addr_q != PLL_ADDR);
                        cnt_d      = 5'd0;
                        if (STREAM) addr_d  = addr_inc;
                        else        state_d = ST_WAIT;
                    end
                end
            end
            ST_RDATA: begin
                if (ce_s2_q) begin
                    state_d     = ST_IDLE;
                    oe_d        = 1'b0;
                    out_d       = 1'b0;
                    frame_err_d = (cnt_q != 5'd0) && (cnt_q != 5'd8);
                end else if (sclk_rise) begin
                    cnt_d = cnt_q + 5'd1;
                end else if (sclk_fall) begin
                    if (cnt_q == 5'd8) begin
                        if (STREAM) begin
                            addr_d  = addr_inc;
                            out_d   = next_byte[7];
                            rd_sh_d = {next_byte[6:0], 1'b0};
                            cnt_d   = 5'd0;
                        end else begin
                            oe_d    = 1'b0;
                            out_d   = 1'b0;
                            state_d = ST_WAIT;
                        end
                    end else begin
                        oe_d    = 1'b1;
                        out_d   = rd_sh_q[7];
                        rd_sh_d = {rd_sh_q[6:0], 1'b0};
                    end
                end
            end
            ST_WAIT: begin
                oe_d  = 1'b0;
                out_d = 1'b0;
                if (ce_s2_q) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                oe_d    = 1'b0;
                out_d   = 1'b0;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 5'd0;
            sr_q        <= 16'h0000;
            addr_q      <= 13'd0;
            two_q       <= 1'b0;
            rd_sh_q     <= 8'h00;
            out_q       <= 1'b0;
            oe_q        <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= 13'd0;
            wr_data_q   <= 8'h00;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            addr_q      <= addr_d;
            two_q       <= two_d;
            rd_sh_q     <= rd_sh_d;
            out_q       <= out_d;
            oe_q        <= oe_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Register file; cleared on reset so it cannot map to block RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else if (we) begin
            regs_q[addr_q[AW-1:0]] <= sr_shift[7:0];
        end
    end

    assign spi_out   = out_q;
    assign spi_oe    = oe_q;
    assign wr_valid  = wr_valid_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = frame_err_q;

endmodule
